// File: rtl/pe_pkg.sv
// Shared constants and types for the systolic MAC processing elements.
// Default Q6.10 format, its range limits and the operating-mode encoding.
package pe_pkg;

  localparam int PE_WIDTH    = 16;
  localparam int PE_FRAC_BIT = 10;

  localparam logic signed [PE_WIDTH-1:0] QMAX = {1'b0, {(PE_WIDTH-1){1'b1}}};
  localparam logic signed [PE_WIDTH-1:0] QMIN = {1'b1, {(PE_WIDTH-1){1'b0}}};
  localparam logic [PE_WIDTH-1:0] ROUND_HALF = PE_WIDTH'(1) << (PE_FRAC_BIT - 1);

  typedef enum logic {
    MODE_SYS = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

endpackage

// File: rtl/q_rescale_sat.sv
// Combinational Q-format rescale of a full-width product, addend, and clamp/wrap.
// Everything is evaluated one bit wider than the product, so no intermediate step loses information.
module q_rescale_sat #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1
) (
  input  logic signed [2*WIDTH-1:0] prod,
  input  logic signed [WIDTH-1:0]   addend,
  output logic        [WIDTH-1:0]   res,
  output logic                      ovf
);

  localparam int EW = 2 * WIDTH + 1;
  localparam logic signed [EW-1:0] RND =
    (ROUND != 0) ? (EW'(1) << (FRAC_BIT - 1)) : '0;
  localparam logic signed [EW-1:0] SUM_MAX = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SUM_MIN = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [EW-1:0] prod_x;
  logic signed [EW-1:0] shifted;
  logic signed [EW-1:0] addend_x;
  logic signed [EW-1:0] sum;

  always_comb begin
    prod_x   = {prod[2*WIDTH-1], prod};
    shifted  = (prod_x + RND) >>> FRAC_BIT;
    addend_x = {{(EW-WIDTH){addend[WIDTH-1]}}, addend};
    sum      = shifted + addend_x;
    ovf      = (sum > SUM_MAX) || (sum < SUM_MIN);
    res      = sum[WIDTH-1:0];
    if ((SATURATE != 0) && ovf) begin
      res = sum[EW-1] ? SUM_MIN[WIDTH-1:0] : SUM_MAX[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pe_mac_pipe.sv
// Weight-stationary, two-stage pipelined signed fixed-point MAC cell for the systolic array.
// Stage 1 registers the full product; stage 2 rescales, adds y_in or the local accumulator, and clamps.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int WIDTH    = PE_WIDTH,
  parameter int FRAC_BIT = PE_FRAC_BIT,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_load,
  input  logic [WIDTH-1:0] w_in,
  output logic [WIDTH-1:0] w_out,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             mode_acc,
  input  logic             acc_clr,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] y_out,
  output logic             valid_out,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0]     w_q, w_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 v1_q, v1_d;
  logic signed [PW-1:0] prod1_q, prod1_d;
  logic [WIDTH-1:0]     y1_q, y1_d;
  mode_e                m1_q, m1_d;
  logic                 c1_q, c1_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic                 vout_q, vout_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic signed [PW-1:0]    a_x, w_x;
  logic signed [WIDTH-1:0] addend;
  logic [WIDTH-1:0]        res;
  logic                    res_ovf;

  // Stage 1: the multiply uses the weight as it stood before any load in this cycle.
  always_comb begin
    w_d     = w_load ? w_in : w_q;
    a_d     = a_in;
    v1_d    = valid_in;
    a_x     = {{WIDTH{a_in[WIDTH-1]}}, a_in};
    w_x     = {{WIDTH{w_q[WIDTH-1]}}, w_q};
    prod1_d = prod1_q;
    y1_d    = y1_q;
    m1_d    = m1_q;
    c1_d    = c1_q;
    if (valid_in) begin
      prod1_d = a_x * w_x;
      y1_d    = y_in;
      m1_d    = mode_e'(mode_acc);
      c1_d    = acc_clr;
    end
  end

  assign addend = (m1_q == MODE_ACC) ? (c1_q ? '0 : acc_q) : y1_q;

  q_rescale_sat #(
    .WIDTH    (WIDTH),
    .FRAC_BIT (FRAC_BIT),
    .SATURATE (SATURATE),
    .ROUND    (ROUND)
  ) u_rescale (
    .prod   (prod1_q),
    .addend (addend),
    .res    (res),
    .ovf    (res_ovf)
  );

  // Stage 2: a new overflow takes priority over a clear in the same cycle.
  always_comb begin
    y_d    = y_q;
    acc_d  = acc_q;
    vout_d = v1_q;
    ovf_d  = ovf_q;
    if (v1_q) begin
      y_d = res;
      if (m1_q == MODE_ACC) begin
        acc_d = res;
      end
    end
    if (v1_q && res_ovf) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      a_q     <= '0;
      v1_q    <= 1'b0;
      prod1_q <= '0;
      y1_q    <= '0;
      m1_q    <= MODE_SYS;
      c1_q    <= 1'b0;
      y_q     <= '0;
      vout_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      w_q     <= w_d;
      a_q     <= a_d;
      v1_q    <= v1_d;
      prod1_q <= prod1_d;
      y1_q    <= y1_d;
      m1_q    <= m1_d;
      c1_q    <= c1_d;
      y_q     <= y_d;
      vout_q  <= vout_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_out     = w_q;
  assign a_out     = a_q;
  assign y_out     = y_q;
  assign valid_out = vout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Self-checking bench for pe_mac_pipe (Q6.10, saturating, rounding): directed table,
// randomized ops against an arithmetic reference model, and reset with ops in flight.
module tb_pe_mac_pipe;

  localparam int W = 16;
  localparam int F = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_load = 1'b0;
  logic [W-1:0]  w_in = '0;
  logic [W-1:0]  w_out;
  logic          valid_in = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  y_in = '0;
  logic          mode_acc = 1'b0;
  logic          acc_clr = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [W-1:0]  a_out;
  logic [W-1:0]  y_out;
  logic          valid_out;
  logic          ovf;

  always #5 clk = ~clk;

  pe_mac_pipe #(.WIDTH(W), .FRAC_BIT(F), .SATURATE(1), .ROUND(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_load    (w_load),
    .w_in      (w_in),
    .w_out     (w_out),
    .valid_in  (valid_in),
    .a_in      (a_in),
    .y_in      (y_in),
    .mode_acc  (mode_acc),
    .acc_clr   (acc_clr),
    .ovf_clr   (ovf_clr),
    .a_out     (a_out),
    .y_out     (y_out),
    .valid_out (valid_out),
    .ovf       (ovf)
  );

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // Reference model state: results are scheduled by the edge at which they must appear.
  logic [W-1:0] m_w = '0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_yhold = '0;
  bit           m_ovf = 1'b0;
  bit           pend_v [4];
  logic [W-1:0] pend_y [4];
  bit           pend_s [4];

  typedef struct {
    bit       wl;
    logic [15:0] win;
    bit       v;
    logic [15:0] a;
    logic [15:0] y;
    bit       m;
    bit       c;
    bit       oc;
    bit       ev;
    logic [15:0] ey;
    bit       eo;
  } vec_t;

  vec_t vecs [29];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Exact arithmetic: real-valued product scaled by 2^F, round half up, add, clamp.
  function automatic void model_op(input longint a, input longint w, input longint add,
                                   output logic [W-1:0] r, output bit ov);
    longint p, s, sum;
    p   = a * w;
    s   = (p + (longint'(1) << (F - 1))) >>> F;
    sum = s + add;
    ov  = (sum > 32767) || (sum < -32768);
    if (sum > 32767)       r = 16'h7FFF;
    else if (sum < -32768) r = 16'h8000;
    else                   r = sum[15:0];
  endfunction

  task automatic model_clear();
    m_w = '0; m_acc = '0; m_yhold = '0; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pend_v[i] = 1'b0; pend_y[i] = '0; pend_s[i] = 1'b0;
    end
  endtask

  task automatic step(input bit wl, input logic [W-1:0] win, input bit v,
                      input logic [W-1:0] a, input logic [W-1:0] y,
                      input bit m, input bit c, input bit oc);
    int ix, nx;
    bit exp_v;
    logic [W-1:0] r;
    bit ov;
    longint addend;
    w_load = wl; w_in = win; valid_in = v; a_in = a; y_in = y;
    mode_acc = m; acc_clr = c; ovf_clr = oc;
    @(posedge clk);
    edge_n++;
    ix = edge_n % 4;
    nx = (edge_n + 1) % 4;
    exp_v = pend_v[ix];
    if (pend_v[ix]) m_yhold = pend_y[ix];
    if (pend_s[ix]) m_ovf = 1'b1;
    else if (oc)    m_ovf = 1'b0;
    pend_v[ix] = 1'b0;
    pend_s[ix] = 1'b0;
    if (v) begin
      addend = m ? (c ? 0 : sx(m_acc)) : sx(y);
      model_op(sx(a), sx(m_w), addend, r, ov);
      pend_v[nx] = 1'b1; pend_y[nx] = r; pend_s[nx] = ov;
      if (m) m_acc = r;
    end
    if (wl) m_w = win;
    #1;
    check("valid_out", 32'(valid_out), 32'(exp_v));
    check("y_out", 32'(y_out), 32'(m_yhold));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("a_out", 32'(a_out), 32'(a));
    check("w_out", 32'(w_out), 32'(m_w));
  endtask

  task automatic idle(input bit oc);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, oc);
  endtask

  initial begin
    //          wl  win       v  a         y         m  c  oc  ev ey        eo
    vecs[0]  = '{1, 16'h0600, 0, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h0000, 0};
    vecs[1]  = '{0, 16'h0000, 1, 16'h0800, 16'h0400, 0, 0, 0,  0, 16'h0000, 0};
    vecs[2]  = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h1000, 0};
    vecs[3]  = '{1, 16'h0200, 0, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h1000, 0};
    vecs[4]  = '{0, 16'h0000, 1, 16'hFC00, 16'h0000, 0, 0, 0,  0, 16'h1000, 0};
    vecs[5]  = '{0, 16'h0000, 1, 16'h0001, 16'h0000, 0, 0, 0,  1, 16'hFE00, 0};
    vecs[6]  = '{1, 16'h7FFF, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0001, 0};
    vecs[7]  = '{0, 16'h0000, 1, 16'h7FFF, 16'h7000, 0, 0, 0,  0, 16'h0001, 0};
    vecs[8]  = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h7FFF, 1};
    vecs[9]  = '{0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h7FFF, 1};
    vecs[10] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0000, 1};
    vecs[11] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1,  0, 16'h0000, 0};
    vecs[12] = '{1, 16'h0400, 0, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h0000, 0};
    vecs[13] = '{0, 16'h0000, 1, 16'h0400, 16'h0000, 1, 1, 0,  0, 16'h0000, 0};
    vecs[14] = '{0, 16'h0000, 1, 16'h0400, 16'h0000, 1, 0, 0,  1, 16'h0400, 0};
    vecs[15] = '{0, 16'h0000, 1, 16'h0400, 16'h0000, 1, 0, 0,  1, 16'h0800, 0};
    vecs[16] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0C00, 0};
    vecs[17] = '{0, 16'h0000, 1, 16'h0400, 16'h0000, 1, 1, 0,  0, 16'h0C00, 0};
    vecs[18] = '{1, 16'h0800, 1, 16'h0400, 16'h0000, 0, 0, 0,  1, 16'h0400, 0};
    vecs[19] = '{0, 16'h0000, 1, 16'h0400, 16'h0000, 0, 0, 0,  1, 16'h0400, 0};
    vecs[20] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0800, 0};
    vecs[21] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h0800, 0};
    vecs[22] = '{0, 16'h0000, 1, 16'h0400, 16'h0100, 0, 0, 0,  0, 16'h0800, 0};
    vecs[23] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0900, 0};
    vecs[24] = '{0, 16'h0000, 1, 16'h0200, 16'h0000, 0, 0, 0,  0, 16'h0900, 0};
    vecs[25] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0400, 0};
    vecs[26] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  0, 16'h0400, 0};
    vecs[27] = '{0, 16'h0000, 1, 16'h0400, 16'h0000, 1, 0, 0,  0, 16'h0400, 0};
    vecs[28] = '{0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0,  1, 16'h0C00, 0};

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_w_out", 32'(w_out), 32'd0);
    check("rst_a_out", 32'(a_out), 32'd0);
    #2 rst_n = 1'b1;

    // Directed vectors with constant expectations.
    for (int k = 0; k < 29; k++) begin
      step(vecs[k].wl, vecs[k].win, vecs[k].v, vecs[k].a, vecs[k].y,
           vecs[k].m, vecs[k].c, vecs[k].oc);
      $display("vec %0d: v=%0b a=%h y=%h m=%0b c=%0b -> valid_out=%0b y_out=%h ovf=%0b",
               k, vecs[k].v, vecs[k].a, vecs[k].y, vecs[k].m, vecs[k].c, valid_out, y_out, ovf);
      check("vec_valid_out", 32'(valid_out), 32'(vecs[k].ev));
      check("vec_y_out", 32'(y_out), 32'(vecs[k].ey));
      check("vec_ovf", 32'(ovf), 32'(vecs[k].eo));
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit v, m, c, wl, oc;
      logic [W-1:0] a, y, win;
      v   = ($urandom_range(0, 3) != 0);
      m   = $urandom_range(0, 1) != 0;
      c   = ($urandom_range(0, 3) == 0);
      wl  = ($urandom_range(0, 7) == 0);
      oc  = ($urandom_range(0, 15) == 0);
      a   = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($signed($urandom_range(0, 4095)) - 2048);
      y   = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($signed($urandom_range(0, 4095)) - 2048);
      win = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($signed($urandom_range(0, 4095)) - 2048);
      step(wl, win, v, a, y, m, c, oc);
      $display("rnd %0d: v=%0b a=%h y=%h m=%0b c=%0b wl=%0b -> valid_out=%0b y_out=%h ovf=%0b",
               i, v, a, y, m, c, wl, valid_out, y_out, ovf);
    end

    // Reset with ops in flight and ovf set.
    step(1'b1, 16'h7FFF, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 16'h7FFF, 16'h7000, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    step(1'b0, '0, 1'b1, 16'h0400, '0, 1'b1, 1'b0, 1'b0);
    w_load = 1'b0; valid_in = 1'b1; a_in = 16'h0400; mode_acc = 1'b1; acc_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_out", 32'(valid_out), 32'd0);
    check("arst_y_out", 32'(y_out), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_w_out", 32'(w_out), 32'd0);
    check("arst_a_out", 32'(a_out), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    valid_in = 1'b0; a_in = '0; mode_acc = 1'b0;
    rst_n = 1'b1;
    model_clear();
    $display("reset applied with ops in flight");
    for (int i = 0; i < 3; i++) idle(1'b0);
    step(1'b1, 16'h0400, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 16'h0400, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    $display("post-reset acc op -> valid_out=%0b y_out=%h", valid_out, y_out);
    check("post_rst_valid", 32'(valid_out), 32'd1);
    check("post_rst_acc", 32'(y_out), 32'h0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
